// File: rtl/scan_decoder_pkg.sv
// Shared types, constants and the one-hot helper for the scan decoder.
// Optional break-before-make blanking is enabled by SCAN_DECODER_BLANK_EN.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
    localparam int   MAX_SEL_W   = 6;

    function automatic logic [63:0] onehot(
        input logic [MAX_SEL_W-1:0] i_idx,
        input int                   n
    );
        logic [63:0] w_v;
        w_v = '0;
        if (int'(i_idx) < n) begin
            w_v[i_idx] = 1'b1;
        end
        return w_v;
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Direct-mode index request channel (valid/ready + index).
// Master drives the request, the decoder answers with sel_ready.
interface scan_decoder_if #(
    parameter int SEL_W = 4
) ();
    logic             sel_valid;
    logic             sel_ready;
    logic [SEL_W-1:0] sel;

    modport master (output sel_valid, output sel, input sel_ready);
    modport slave  (input sel_valid, input sel, output sel_ready);
endinterface

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decode.
// Generalises the fixed 4-to-16 decoder; holds no state.
module onehot_dec
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int N     = 2**SEL_W
) (
    input  logic [SEL_W-1:0] i_idx,
    output logic [N-1:0]     o_sel
);
    assign o_sel = N'(onehot(MAX_SEL_W'(i_idx), N));
endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot select driver with direct (handshake) and scan modes.
// Define SCAN_DECODER_BLANK_EN for a one-cycle blank on every index change.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter  int SEL_W   = 4,
    parameter  int DWELL_W = 8,
    localparam int N       = 2**SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    scan_decoder_if.slave      sel_if,
    output logic [N-1:0]       o,
    output logic [SEL_W-1:0]   idx,
    output logic               wrap
);

    state_t             r_state;
    logic [SEL_W-1:0]   r_idx;
    logic [DWELL_W-1:0] r_cnt;
    logic [N-1:0]       r_o;
    logic               r_wrap;

    state_t             w_state_nx;
    logic [SEL_W-1:0]   w_idx_nx;
    logic [DWELL_W-1:0] w_cnt_nx;
    logic               w_wrap_nx;
    logic               w_ready;
    logic               w_accept;
    logic               w_show;
    logic [N-1:0]       w_dec;

    // Gated by rst_n so the request channel reads not-ready during reset
    assign w_ready  = rst_n & (r_state != SCAN) & (mode == MODE_DIRECT);
    assign w_accept = sel_if.sel_valid & w_ready;
    assign sel_if.sel_ready = w_ready;

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_wrap_nx  = 1'b0;
        unique case (r_state)
            IDLE, HOLD: begin
                if (mode == MODE_SCAN) begin
                    w_state_nx = SCAN;
                    w_idx_nx   = '0;
                    w_cnt_nx   = dwell;
                end else if (w_accept) begin
                    w_state_nx = HOLD;
                    w_idx_nx   = sel_if.sel;
                end
            end
            SCAN: begin
                if (mode == MODE_DIRECT) begin
                    w_state_nx = HOLD;
                end else if (r_cnt == '0) begin
                    w_idx_nx  = r_idx + SEL_W'(1);
                    w_cnt_nx  = dwell;
                    w_wrap_nx = (r_idx == SEL_W'(N-1));
                end else begin
                    w_cnt_nx = r_cnt - DWELL_W'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_idx_nx   = '0;
                w_cnt_nx   = '0;
            end
        endcase
    end

`ifdef SCAN_DECODER_BLANK_EN
    assign w_show = en & (w_state_nx != IDLE)
                  & (w_idx_nx == r_idx)
                  & ~((w_state_nx == SCAN) & (r_state != SCAN));
`else
    assign w_show = en & (w_state_nx != IDLE);
`endif

    onehot_dec #(
        .SEL_W (SEL_W),
        .N     (N)
    ) u_dec (
        .i_idx (w_idx_nx),
        .o_sel (w_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_o     <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
            r_o     <= w_show ? w_dec : '0;
            r_wrap  <= w_wrap_nx;
        end
    end

    assign o    = r_o;
    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule
